// File: rtl/ysyx_22040632_icache.sv
// ysyx_22040632_icache: direct-mapped I-cache, 128-bit lines, AXI4 read refill.
// Ports: clk/rst, fetch channel (ic_*), fence_i, AXI AR/R master, perf counters.
module ysyx_22040632_icache #(
  parameter int NSETS     = 16,
  parameter int LINE_BITS = 128,
  parameter int AXI_DW    = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ic_valid,
  input  logic [31:0]          ic_pc,
  input  logic                 ic_uncacheable,
  output logic                 ic_ready,
  output logic [LINE_BITS-1:0] ic_inst,
  output logic                 ic_err,
  input  logic                 fence_i,
  output logic                 arvalid,
  input  logic                 arready,
  output logic [31:0]          araddr,
  output logic [7:0]           arlen,
  output logic [2:0]           arsize,
  output logic [1:0]           arburst,
  input  logic                 rvalid,
  output logic                 rready,
  input  logic [AXI_DW-1:0]    rdata,
  input  logic [1:0]           rresp,
  input  logic                 rlast,
  output logic [31:0]          perf_hit,
  output logic [31:0]          perf_miss
);

  localparam int IW = $clog2(NSETS);
  localparam int TW = 28 - IW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIT,
    S_AR,
    S_R,
    S_RESP
  } state_t;

  state_t state, state_nx;

  logic [31:0]          req_pc;
  logic                 req_unc;
  logic [NSETS-1:0]     valid_q;
  logic [TW-1:0]        tag_q  [NSETS];
  logic [LINE_BITS-1:0] data_q [NSETS];
  logic [AXI_DW-1:0]    line_lo;
  logic                 beat_q;
  logic                 err_q;
  logic                 inh_q;

  logic [IW-1:0]        lk_idx;
  logic [TW-1:0]        lk_tag;
  logic                 lk_hit;
  logic [IW-1:0]        rq_idx;
  logic [TW-1:0]        rq_tag;
  logic                 take;
  logic                 r_fire;
  logic                 last_fire;
  logic                 err_fin;
  logic                 resp_ok;
  logic                 fill_we;
  logic [AXI_DW-1:0]    lo_fin;
  logic [AXI_DW-1:0]    hi_fin;
  logic [LINE_BITS-1:0] fill_line;

  assign lk_idx = ic_pc[3+IW:4];
  assign lk_tag = ic_pc[31:4+IW];
  assign lk_hit = valid_q[lk_idx] &&
                  (tag_q[lk_idx] == lk_tag);
  assign rq_idx = req_pc[3+IW:4];
  assign rq_tag = req_pc[31:4+IW];

  // fence_i in IDLE swallows the lookup for that cycle
  assign take = (state == S_IDLE) &&
                ic_valid && !fence_i;

  assign r_fire    = (state == S_R) && rvalid;
  assign last_fire = r_fire && rlast;
  assign err_fin   = err_q | (rresp != 2'b00);

  // early rlast leaves the upper half zero
  assign lo_fin = beat_q ? line_lo : rdata;
  assign hi_fin = (beat_q && !req_unc) ?
                  rdata : '0;
  assign fill_line = {hi_fin, lo_fin};

  assign resp_ok = ic_valid && (ic_pc == req_pc);
  assign fill_we = last_fire && !req_unc &&
                   !err_fin && !inh_q;

  assign arvalid = (state == S_AR);
  assign rready  = (state == S_R);
  assign araddr  = req_unc ?
                   {req_pc[31:3], 3'b000} :
                   {req_pc[31:4], 4'h0};
  assign arlen   = req_unc ? 8'd0 : 8'd1;
  assign arsize  = 3'd3;
  assign arburst = 2'b01;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (take)
          state_nx = (!ic_uncacheable && lk_hit) ?
                     S_HIT : S_AR;
      end
      S_HIT:  state_nx = S_IDLE;
      S_AR:   if (arready) state_nx = S_R;
      S_R:    if (last_fire) state_nx = S_RESP;
      S_RESP: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      ic_ready  <= 1'b0;
      ic_err    <= 1'b0;
      ic_inst   <= '0;
      perf_hit  <= '0;
      perf_miss <= '0;
      req_pc    <= '0;
      req_unc   <= 1'b0;
      beat_q    <= 1'b0;
      err_q     <= 1'b0;
      inh_q     <= 1'b0;
    end else begin
      ic_ready <= 1'b0;
      ic_err   <= 1'b0;
      if (take) begin
        req_pc  <= ic_pc;
        req_unc <= ic_uncacheable;
        beat_q  <= 1'b0;
        err_q   <= 1'b0;
        inh_q   <= 1'b0;
        if (!ic_uncacheable) begin
          if (lk_hit) begin
            perf_hit <= perf_hit + 32'd1;
            ic_ready <= 1'b1;
            ic_inst  <= data_q[lk_idx];
          end else begin
            perf_miss <= perf_miss + 32'd1;
          end
        end
      end
      if (r_fire) begin
        beat_q <= 1'b1;
        err_q  <= err_fin;
      end
      // stale requester: fill still lands, reply dropped
      if (last_fire && resp_ok) begin
        ic_ready <= 1'b1;
        ic_err   <= err_fin;
        ic_inst  <= fill_line;
      end
      if (fence_i &&
          (state == S_AR || state == S_R))
        inh_q <= 1'b1;
      if (fence_i)
        valid_q <= '0;
      else if (fill_we)
        valid_q[rq_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_fire && !beat_q)
      line_lo <= rdata;
    if (fill_we) begin
      tag_q[rq_idx]  <= rq_tag;
      data_q[rq_idx] <= fill_line;
    end
  end

endmodule

// File: tb/tb_ysyx_22040632_icache.sv
// tb_ysyx_22040632_icache: scoreboard bench for the I-cache.
// Directed fetch/AXI traffic; monitor pops expected lines on ic_ready.
module tb_ysyx_22040632_icache;

  logic         clk;
  logic         rst;
  logic         ic_valid;
  logic [31:0]  ic_pc;
  logic         ic_uncacheable;
  logic         ic_ready;
  logic [127:0] ic_inst;
  logic         ic_err;
  logic         fence_i;
  logic         arvalid;
  logic         arready;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         rvalid;
  logic         rready;
  logic [63:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic [31:0]  perf_hit;
  logic [31:0]  perf_miss;

  ysyx_22040632_icache dut (
    .clk(clk), .rst(rst),
    .ic_valid(ic_valid), .ic_pc(ic_pc),
    .ic_uncacheable(ic_uncacheable),
    .ic_ready(ic_ready), .ic_inst(ic_inst),
    .ic_err(ic_err), .fence_i(fence_i),
    .arvalid(arvalid), .arready(arready),
    .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready),
    .rdata(rdata), .rresp(rresp),
    .rlast(rlast),
    .perf_hit(perf_hit), .perf_miss(perf_miss)
  );

  typedef struct packed {
    logic [127:0] inst;
    logic         err;
  } exp_t;

  exp_t q[$];
  int   tests;
  int   fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (!rst && ic_ready === 1'b1) begin
      exp_t e;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ready inst=%h err=%b",
                 ic_inst, ic_err);
      end else begin
        e = q.pop_front();
        if (ic_inst !== e.inst || ic_err !== e.err) begin
          fails++;
          $display("FAIL sb_line got=%h/%b exp=%h/%b",
                   ic_inst, ic_err, e.inst, e.err);
        end
      end
    end
  end

  task automatic chk(input string n,
                     input logic [127:0] a,
                     input logic [127:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [127:0] l,
                      input logic er);
    exp_t e;
    e.inst = l;
    e.err  = er;
    q.push_back(e);
  endtask

  task automatic req(input logic [31:0] pc);
    ic_pc    = pc;
    ic_valid = 1'b1;
  endtask

  task automatic end_req();
    tick();
    ic_valid = 1'b0;
  endtask

  task automatic ar(input logic [31:0] a,
                    input logic [7:0] len);
    int n;
    n = 0;
    while (!arvalid && n < 20) begin
      tick();
      n++;
    end
    chk("arvalid", arvalid, 1);
    chk("araddr", araddr, a);
    chk("arlen", arlen, len);
    chk("arsize_burst", {arsize, arburst}, 5'b011_01);
    arready = 1'b1;
    tick();
    arready = 1'b0;
  endtask

  task automatic beat(input logic [63:0] d,
                      input logic [1:0] rs,
                      input logic l,
                      input logic f);
    int n;
    rvalid = 1'b1;
    rdata  = d;
    rresp  = rs;
    rlast  = l;
    n = 0;
    while (!rready && n < 20) begin
      tick();
      n++;
    end
    chk("rready", rready, 1);
    fence_i = f;
    tick();
    rvalid  = 1'b0;
    rlast   = 1'b0;
    rresp   = 2'b00;
    fence_i = 1'b0;
  endtask

  task automatic miss(input logic [31:0] pc,
                      input logic [63:0] d0,
                      input logic [63:0] d1,
                      input logic [1:0] r0);
    push({d1, d0}, r0 != 2'b00);
    req(pc);
    ar({pc[31:4], 4'h0}, 8'd1);
    beat(d0, r0, 1'b0, 1'b0);
    beat(d1, 2'b00, 1'b1, 1'b0);
    chk("ready_after_rlast", ic_ready, 1);
    end_req();
  endtask

  task automatic hit(input logic [31:0] pc,
                     input logic [127:0] l);
    push(l, 1'b0);
    req(pc);
    tick();
    chk("hit_ready_n1", ic_ready, 1);
    chk("hit_no_ar", arvalid, 0);
    end_req();
  endtask

  localparam logic [63:0] A0 = 64'h1111111111111111;
  localparam logic [63:0] A1 = 64'h2222222222222222;
  localparam logic [63:0] UD = 64'hDEADBEEF12345678;

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    ic_valid = 1'b0;
    ic_pc = '0;
    ic_uncacheable = 1'b0;
    fence_i = 1'b0;
    arready = 1'b0;
    rvalid = 1'b0;
    rdata = '0;
    rresp = '0;
    rlast = 1'b0;
    repeat (3) tick();
    chk("rst_ready", ic_ready, 0);
    chk("rst_axi", {arvalid, rready}, 0);
    chk("rst_inst", ic_inst, 0);
    chk("rst_err", ic_err, 0);
    chk("rst_perf", {perf_hit, perf_miss}, 0);
    rst = 1'b0;
    tick();

    miss(32'h8000_0000, A0, A1, 2'b00);
    chk("perf_miss_1", perf_miss, 1);
    hit(32'h8000_0008, {A1, A0});
    chk("perf_hit_1", perf_hit, 1);

    repeat (2) begin
      push({64'h0, UD}, 1'b0);
      ic_uncacheable = 1'b1;
      req(32'hA000_0004);
      ar(32'hA000_0000, 8'd0);
      beat(UD, 2'b00, 1'b1, 1'b0);
      chk("unc_ready", ic_ready, 1);
      end_req();
      ic_uncacheable = 1'b0;
    end
    chk("unc_no_count", {perf_hit, perf_miss}, {32'd1, 32'd1});

    push({64'h4444444444444444, 64'h3333333333333333}, 1'b0);
    req(32'h8000_0010);
    ar(32'h8000_0010, 8'd1);
    beat(64'h3333333333333333, 2'b00, 1'b0, 1'b1);
    beat(64'h4444444444444444, 2'b00, 1'b1, 1'b0);
    end_req();
    miss(32'h8000_0010, 64'h5555555555555555,
         64'h6666666666666666, 2'b00);
    chk("perf_miss_fence", perf_miss, 3);

    miss(32'h8000_0000, 64'hA1, 64'hA2, 2'b00);
    miss(32'h8000_0100, 64'hB1, 64'hB2, 2'b00);
    miss(32'h8000_0000, 64'hC1, 64'hC2, 2'b10);
    miss(32'h8000_0000, 64'hD1, 64'hD2, 2'b00);
    hit(32'h8000_0000, {64'hD2, 64'hD1});
    chk("perf_conflict", {perf_hit, perf_miss}, {32'd2, 32'd7});

    fence_i = 1'b1;
    tick();
    fence_i = 1'b0;
    req(32'h8000_0000);
    ar(32'h8000_0000, 8'd1);
    beat(64'hE1, 2'b00, 1'b0, 1'b0);
    ic_pc = 32'h8000_0020;
    beat(64'hE2, 2'b00, 1'b1, 1'b0);
    chk("drop_old", ic_ready, 0);
    push({64'hF2, 64'hF1}, 1'b0);
    ar(32'h8000_0020, 8'd1);
    beat(64'hF1, 2'b00, 1'b0, 1'b0);
    beat(64'hF2, 2'b00, 1'b1, 1'b0);
    chk("new_ready", ic_ready, 1);
    end_req();
    hit(32'h8000_0000, {64'hE2, 64'hE1});
    chk("perf_redirect", {perf_hit, perf_miss}, {32'd3, 32'd9});

    ic_pc = 32'h8000_0000;
    ic_valid = 1'b1;
    fence_i = 1'b1;
    tick();
    fence_i = 1'b0;
    chk("fence_wins", {arvalid, ic_ready}, 0);
    push({64'h72, 64'h71}, 1'b0);
    ar(32'h8000_0000, 8'd1);
    beat(64'h71, 2'b00, 1'b0, 1'b0);
    beat(64'h72, 2'b00, 1'b1, 1'b0);
    end_req();
    chk("perf_miss_10", perf_miss, 10);

    req(32'h8000_0040);
    ar(32'h8000_0040, 8'd1);
    beat(64'h81, 2'b00, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk("mid_rst_axi", {arvalid, rready}, 0);
    chk("mid_rst_out", {ic_ready, ic_err, ic_inst}, 0);
    chk("mid_rst_perf", {perf_hit, perf_miss}, 0);
    ic_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    miss(32'h8000_0000, 64'h91, 64'h92, 2'b00);
    chk("post_rst_miss", perf_miss, 1);

    repeat (3) tick();
    chk("sb_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_22040632_icache.md
Name: ysyx_22040632_icache

Overview:
Direct-mapped instruction cache sitting directly downstream of the fetch unit on the fetch-to-cache channel. It returns a 128-bit line (four instructions) per request and refills misses over an AXI4 read-only master with 64-bit data. Uncacheable requests bypass the arrays as a single 64-bit AXI beat. Supports whole-cache invalidation for fence.i and keeps hit/miss performance counters.

Parameters:
NSETS, 16, number of lines (power of two); index = pc[3+log2(NSETS):4]
LINE_BITS, 128, line size in bits (fixed: 2 AXI beats of 64)
AXI_DW, 64, AXI read data width (fixed)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
ic_valid  in  1  fetch request valid (level, held until ic_ready)
ic_pc  in  32  fetch address
ic_uncacheable  in  1  request bypasses arrays
ic_ready  out  1  one-cycle pulse: ic_inst valid for the current request
ic_inst  out  128  line data; uncacheable: [63:0]=beat, [127:64]=0; held stable until next ic_ready
ic_err  out  1  pulses with ic_ready when any rresp!=0
fence_i  in  1  invalidate all lines
arvalid/arready  out/in  1  AXI AR handshake
araddr  out  32  read address
arlen  out  8  burst length-1
arsize  out  3  fixed 3'd3
arburst  out  2  fixed 2'b01 INCR
rvalid/rready  in/out  1  AXI R handshake
rdata  in  64  read data
rresp  in  2  read response
rlast  in  1  last beat
perf_hit  out  32  cacheable hit count
perf_miss  out  32  cacheable miss count

Behaviour:
- Reset (synchronous, rst=1 at clk edge): all valid bits 0, state IDLE, arvalid=0, rready=0, ic_ready=0, ic_err=0, ic_inst=0, perf_hit=perf_miss=0.
- Tag = pc[31:4+log2(NSETS)]; arrays: valid bits in flops, tag/data in flops (no SRAM macro).
- FSM states: IDLE, HIT, AR, R, RESP.
- IDLE: on ic_valid, latch req_pc, req_unc. Cacheable hit -> HIT, perf_hit+1. Cacheable miss -> AR, perf_miss+1. Uncacheable -> AR, no counter.
- HIT: ic_ready=1, ic_inst=data[index] for one cycle -> IDLE. Hit latency: ready in cycle N+1 after valid sampled in N.
- AR: arvalid=1 until arready; cacheable araddr={req_pc[31:4],4'h0}, arlen=1; uncacheable araddr={req_pc[31:3],3'h0}, arlen=0. arvalid never drops before handshake. -> R.
- R: rready=1; beat0 -> line[63:0], beat1 -> line[127:64]; uncacheable single beat -> [63:0]. Accumulate err |= (rresp!=0). On rlast handshake -> RESP; cacheable and no err and no inhibit: write data, tag, set valid.
- RESP: ic_ready=1 only if ic_valid && ic_pc==req_pc; else silent drop (fill still done). ic_err=err. -> IDLE.
- rlast arriving early/late vs arlen: FSM exits R on rlast only.
- fence_i: clears all valid bits that cycle; if in AR/R, set inhibit so in-flight fill does not set valid (data still returned). fence_i in IDLE with ic_valid: invalidation wins, request is looked up next cycle (no lookup that cycle).
- Same-cycle fill and fence_i: fence wins, valid cleared.
- Counters wrap at 2^32.
- Reset mid-burst: FSM to IDLE immediately; subsequent stray R beats accepted by nothing (rready=0); interconnect is reset jointly.
- ic_inst register updates only on HIT/RESP entry, otherwise holds.

Test Plan:
- Cold miss pc=0x8000_0000: AR araddr=0x8000_0000 arlen=1; beats 0x11..,0x22.. -> ic_inst={0x22..,0x11..}, ic_ready pulse 1 cycle after rlast; perf_miss=1.
- Re-request 0x8000_0008 -> ic_ready at N+1, no AR, same line; perf_hit=1.
- Uncacheable pc=0xA000_0004: araddr=0xA000_0000 arlen=0; rdata=0xDEADBEEF_12345678 -> ic_inst[63:0] matches, [127:64]=0; later same pc misses again (no fill).
- fence_i during R of miss at 0x8000_0010 -> data returned, then re-request misses (AR issued again).
- Conflict: 0x8000_0000 then 0x8000_0100 (NSETS=16, same index) -> both miss, second evicts first; rresp=2 on a beat -> ic_err pulse, line not valid.
- ic_pc changed to 0x8000_0020 while filling 0x8000_0000 -> no ic_ready for old; next IDLE serves new pc; reset asserted mid-R -> all outputs zero next cycle.
